// File: rtl/exanet_crosb_pkg.sv
// Shared types and constants for the crossbar VC credit controller.
package exanet_crosb_pkg;

    localparam int CREDITS_DEFAULT = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } crosb_state_e;

    // Index width that stays at least one bit when there is a single VC.
    function automatic int vcIndexWidth(input int numVc);
        return (numVc > 1) ? $clog2(numVc) : 1;
    endfunction

endpackage

// File: rtl/exa_crosb_vc_credit_ctrl_if.sv
// Upstream flit, downstream flit, credit return and credit status bundle.
interface exa_crosb_vc_credit_ctrl_if
    import exanet_crosb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int VC_W   = 2,
    parameter int NUM_VC = 4,
    parameter int CNT_W  = $clog2(CREDITS_DEFAULT + 1)
);
    logic                         i_tvalid;
    logic [DATA_W-1:0]            i_tdata;
    logic                         i_tlast;
    logic [VC_W-1:0]              i_tvc;
    logic                         o_tready;
    logic                         o_tvalid;
    logic [DATA_W-1:0]            o_tdata;
    logic                         o_tlast;
    logic [VC_W-1:0]              o_tvc;
    logic                         i_tready;
    logic                         i_credit_valid;
    logic [VC_W-1:0]              i_credit_vc;
    logic [NUM_VC-1:0][CNT_W-1:0] o_credit_cnt;
    logic                         o_credit_err;

    modport master (
        output i_tvalid, i_tdata, i_tlast, i_tvc, i_tready, i_credit_valid, i_credit_vc,
        input  o_tready, o_tvalid, o_tdata, o_tlast, o_tvc, o_credit_cnt, o_credit_err
    );

    modport slave (
        input  i_tvalid, i_tdata, i_tlast, i_tvc, i_tready, i_credit_valid, i_credit_vc,
        output o_tready, o_tvalid, o_tdata, o_tlast, o_tvc, o_credit_cnt, o_credit_err
    );
endinterface

// File: rtl/exa_crosb_credit_counter.sv
// Saturating per-VC credit counter; overflow_o flags a return to an already full VC.
module exa_crosb_credit_counter
    import exanet_crosb_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEFAULT,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        unique case ({inc_i, dec_i})
            2'b10: begin
                if (count_q == FULL) overflow_o = 1'b1;
                else                 count_d    = count_q + 1'b1;
            end
            2'b01: begin
                if (count_q != '0) count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) count_q <= FULL;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/exa_crosb_vc_credit_ctrl.sv
// Credit-based VC output stage with packet VC locking and a one-flit output register.
// Optional sticky protocol error flag: define EXA_CROSB_CREDIT_ERR_EN.
module exa_crosb_vc_credit_ctrl
    import exanet_crosb_pkg::*;
#(
    parameter int vc_num    = 2,
    parameter int prio_num  = 2,
    parameter int CREDITS   = CREDITS_DEFAULT,
    parameter int DATA_W    = 64,
    parameter int logVcPrio = vcIndexWidth(prio_num * vc_num),
    parameter int CNT_W     = $clog2(CREDITS + 1)
) (
    input logic                       clk,
    input logic                       resetn,
    exa_crosb_vc_credit_ctrl_if.slave bus
);
    localparam int NUM_VC = prio_num * vc_num;

    crosb_state_e         state_q, state_d;
    logic [logVcPrio-1:0] lockedVc_q, lockedVc_d;
    logic [logVcPrio-1:0] curVc;
    logic [CNT_W-1:0]     credit [NUM_VC];
    logic [NUM_VC-1:0]    incVec, decVec, ovfVec;
    logic                 tready, upXfer, downXfer;

    logic                 outValid_q;
    logic [DATA_W-1:0]    outData_q;
    logic                 outLast_q;
    logic [logVcPrio-1:0] outVc_q;

    // Acceptance looks only at registered credits, so a same-cycle return cannot help.
    assign curVc    = (state_q == ACTIVE) ? lockedVc_q : bus.i_tvc;
    assign tready   = (credit[curVc] != '0) && (!outValid_q || bus.i_tready);
    assign upXfer   = bus.i_tvalid && tready;
    assign downXfer = outValid_q && bus.i_tready;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign decVec[v] = upXfer && (curVc == logVcPrio'(v));
        assign incVec[v] = bus.i_credit_valid && (bus.i_credit_vc == logVcPrio'(v));

        exa_crosb_credit_counter #(
            .CREDITS (CREDITS),
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .resetn     (resetn),
            .inc_i      (incVec[v]),
            .dec_i      (decVec[v]),
            .count_o    (credit[v]),
            .overflow_o (ovfVec[v])
        );

        assign bus.o_credit_cnt[v] = credit[v];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outLast_q  <= 1'b0;
            outVc_q    <= '0;
        end else if (upXfer) begin
            outValid_q <= 1'b1;
            outData_q  <= bus.i_tdata;
            outLast_q  <= bus.i_tlast;
            outVc_q    <= curVc;
        end else if (downXfer) begin
            outValid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            lockedVc_q <= '0;
        end else begin
            state_q    <= state_d;
            lockedVc_q <= lockedVc_d;
        end
    end

    // A head flit without tlast locks its VC for the rest of the packet.
    always_comb begin
        state_d    = state_q;
        lockedVc_d = lockedVc_q;
        unique case (state_q)
            IDLE: begin
                if (upXfer && !bus.i_tlast) begin
                    state_d    = ACTIVE;
                    lockedVc_d = bus.i_tvc;
                end
            end
            ACTIVE: begin
                if (upXfer && bus.i_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef EXA_CROSB_CREDIT_ERR_EN
    logic credErr_q;

    always_ff @(posedge clk) begin
        if (!resetn)
            credErr_q <= 1'b0;
        else if ((|ovfVec) || (state_q == ACTIVE && upXfer && bus.i_tvc != lockedVc_q))
            credErr_q <= 1'b1;
    end

    assign bus.o_credit_err = credErr_q;
`else
    logic unusedOvf;
    assign unusedOvf        = |ovfVec;
    assign bus.o_credit_err = 1'b0;
`endif

    assign bus.o_tready = tready;
    assign bus.o_tvalid = outValid_q;
    assign bus.o_tdata  = outData_q;
    assign bus.o_tlast  = outLast_q;
    assign bus.o_tvc    = outVc_q;

endmodule

// File: doc/exa_crosb_vc_credit_ctrl.md
EXA_CROSB_VC_CREDIT_CTRL -- requirements
Module: exa_crosb_vc_credit_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  vc_num  2  VCs per priority
  prio_num  2  priority levels
  CREDITS  8  downstream buffer depth per VC, in flits
  DATA_W  64  flit width
  logVcPrio  log2(prio_num*vc_num)  VC index width (derived)
  CNT_W  log2(CREDITS+1)  credit counter width (derived)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock
  resetn  in  1  reset, synchronous, active-low
  i_tvalid  in  1  upstream flit valid
  i_tdata  in  DATA_W  flit payload
  i_tlast  in  1  last flit of packet
  i_tvc  in  logVcPrio  output VC from VC allocation, valid with head flit
  o_tready  out  1  flit accepted
  o_tvalid  out  1  downstream flit valid
  o_tdata  out  DATA_W  registered payload
  o_tlast  out  1  registered last
  o_tvc  out  logVcPrio  VC the flit occupies downstream
  i_tready  in  1  downstream accept
  i_credit_valid  in  1  downstream returns one credit
  i_credit_vc  in  logVcPrio  VC of returned credit
  o_credit_cnt  out  CNT_W x (prio_num*vc_num)  per-VC credit count
  o_credit_err  out  1  sticky credit/VC protocol error

Function
REQ-003 Per-VC counter credit[v] SHALL count downstream free slots, range 0..CREDITS.
REQ-004 Upstream transfer SHALL occur when i_tvalid && o_tready; downstream transfer when o_tvalid && i_tready.
REQ-005 o_tready SHALL equal (credit[cur_vc] != 0) && (!o_tvalid || i_tready), cur_vc = i_tvc in IDLE, locked_vc in ACTIVE.
REQ-006 Credit check SHALL use the registered counter only; a same-cycle return SHALL NOT enable acceptance that cycle.
REQ-007 On upstream transfer credit[cur_vc] SHALL decrement by 1; on i_credit_valid credit[i_credit_vc] SHALL increment by 1; both on the same VC same cycle SHALL leave it unchanged.
REQ-008 Accepted flit SHALL appear on o_tdata/o_tlast/o_tvc the next cycle (latency 1); output register SHALL hold while o_tvalid && !i_tready.
REQ-009 o_tvalid SHALL clear after downstream transfer with no new upstream transfer that cycle.
REQ-010 FSM states IDLE, ACTIVE: IDLE->ACTIVE on transfer with !i_tlast, latching locked_vc = i_tvc; ACTIVE->IDLE on transfer with i_tlast; single-flit packet (i_tlast in IDLE) SHALL stay IDLE.
REQ-011 In ACTIVE, flits SHALL be forwarded on locked_vc regardless of i_tvc.
REQ-012 Credit return to a VC at CREDITS SHALL saturate (no wrap).
REQ-013 o_credit_cnt SHALL reflect registered counters.

Reset
REQ-014 On !resetn at clk edge: credit[all]=CREDITS, FSM=IDLE, locked_vc=0, o_tvalid=0, o_tlast=0, o_tvc=0, o_tdata=0, o_credit_err=0.
REQ-015 Reset mid-packet SHALL abandon the packet and restore full credits; no flit is emitted after reset until a new transfer.

Configuration
REQ-016 With EXA_CROSB_CREDIT_ERR_EN defined, o_credit_err SHALL set sticky on credit return to a full VC (REQ-012) or on ACTIVE transfer with i_tvc != locked_vc; cleared only by reset.
REQ-017 Without EXA_CROSB_CREDIT_ERR_EN, o_credit_err SHALL be constant 0; saturation and lock behaviour unchanged.

Structure
REQ-018 FSM state enum and default CREDITS constant SHALL reside in exanet_crosb_pkg.
REQ-019 Per-VC counter SHALL be sub-module exa_crosb_credit_counter (inc, dec, saturate, count), instantiated prio_num*vc_num times.

Verification
REQ-020 After reset, 8 single-flit packets on VC2 with i_tready=1, no returns -> 8 accepted, credit[2]=0, o_tready=0 on 9th, VC0 still accepted.
REQ-021 credit[1]=0, i_tvalid on VC1, return on VC1 at cycle t -> o_tready=0 at t, 1 at t+1, flit out at t+2.
REQ-022 3-flit packet, i_tvc=3 on head then 0,1 on body -> all 3 out with o_tvc=3, credit[3]=5, o_credit_err=1 (macro on) / 0 (macro off).
REQ-023 credit[0]=4, simultaneous accept and return on VC0 -> credit[0]=4; return on full VC1 -> stays 8, error set with macro.
REQ-024 i_tready=0 for 5 cycles with o_tvalid=1 -> o_tdata stable, o_tready=0, credits unchanged.
REQ-025 resetn low mid 4-flit packet after 2 flits -> all credits 8, o_tvalid=0, FSM IDLE, next head uses its own i_tvc.
